// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage
// ----------------------------------------------------------------------------
// Purpose:
//   ID/EX pipeline register with execute-stage operand selection.
//   - Captures one decoded instruction per clock edge.
//   - Forwards RAW results from EX/MEM and MEM/WB. EX/MEM has priority.
//   - Detects load-use hazards combinationally and writes a bubble for them.
//
// Update priority on each rising edge:
//   flush > stall > load_use > load
//
// Optional feature macro: ID_EX_STATS_EN
//   When this macro is defined, two free-running 32-bit counters are added:
//   - stat_bubbles
//   - stat_stalls
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   id_*                 decoded instruction fields from the decode stage
//   stall, flush         hold / squash controls for this register
//   mem_rd/we/fwd        EX/MEM forwarding source
//   wb_rd/we/fwd         MEM/WB forwarding source
//   load_use             decode must hold for one cycle (combinational)
//   ex_valid/rd/ctl/pc   registered instruction fields
//   alu_a, alu_b         ALU operand buses
//   alu_ctrl             ALU operation code
//   ex_store_data        forwarded rs2 value for stores
//   stat_bubbles/stalls  event counters (only with ID_EX_STATS_EN)
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_src_a,
    input  logic            id_src_b,
    input  logic [4:0]      id_ctl,
    input  logic            stall,
    input  logic            flush,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic            mem_we,
    input  logic            wb_we,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic [XLEN-1:0] wb_fwd,
    output logic            load_use,
    output logic            ex_valid,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_ctl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] ex_store_data
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]     stat_bubbles,
    output logic [31:0]     stat_stalls
`endif
);

    localparam logic [3:0] ALU_ADD = 4'b0000;

    // ctl bit order: {reg_write, mem_read, mem_write, branch, jump}
    localparam int CTL_MEM_READ = 3;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_ctrl;
        logic            src_a;
        logic            src_b;
        logic [4:0]      ctl;
    } slot_t;

    slot_t slot_q;
    slot_t slot_d;
    slot_t bubble;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // A bubble zeroes every field.
    // Clearing rs1/rs2 as well means a bubble never matches a forwarding source.
    always_comb begin
        bubble          = '0;
        bubble.alu_ctrl = ALU_ADD;
    end

    // The load in EX has no data until MEM.
    // A dependent instruction in decode therefore has to wait one cycle.
    assign load_use = id_valid && slot_q.valid && slot_q.ctl[CTL_MEM_READ] &&
                      (slot_q.rd != 5'd0) &&
                      ((slot_q.rd == id_rs1) || (slot_q.rd == id_rs2));

    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d = bubble;
        end else if (stall) begin
            slot_d = slot_q;
        end else if (load_use || !id_valid) begin
            slot_d = bubble;
        end else begin
            slot_d.valid    = 1'b1;
            slot_d.pc       = id_pc;
            slot_d.rs1      = id_rs1;
            slot_d.rs2      = id_rs2;
            slot_d.rd       = id_rd;
            slot_d.rs1_data = id_rs1_data;
            slot_d.rs2_data = id_rs2_data;
            slot_d.imm      = id_imm;
            slot_d.alu_ctrl = id_alu_ctrl;
            slot_d.src_a    = id_src_a;
            slot_d.src_b    = id_src_b;
            slot_d.ctl      = id_ctl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= bubble;
        end else begin
            slot_q <= slot_d;
        end
    end

    // The younger result (EX/MEM) shadows the older one (MEM/WB).
    // x0 is hard-wired to zero, so it is never forwarded.
    always_comb begin
        fwd_rs1 = slot_q.rs1_data;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == slot_q.rs1)) begin
            fwd_rs1 = mem_fwd;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == slot_q.rs1)) begin
            fwd_rs1 = wb_fwd;
        end

        fwd_rs2 = slot_q.rs2_data;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == slot_q.rs2)) begin
            fwd_rs2 = mem_fwd;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == slot_q.rs2)) begin
            fwd_rs2 = wb_fwd;
        end
    end

    assign alu_a         = slot_q.src_a ? slot_q.pc  : fwd_rs1;
    assign alu_b         = slot_q.src_b ? slot_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_ctrl      = slot_q.alu_ctrl;
    assign ex_valid      = slot_q.valid;
    assign ex_rd         = slot_q.rd;
    assign ex_ctl        = slot_q.ctl;
    assign ex_pc         = slot_q.pc;

`ifdef ID_EX_STATS_EN
    logic [31:0] stat_bubbles_q;
    logic [31:0] stat_stalls_q;

    // Only flush or load-use bubbles are counted.
    // Idle cycles (id_valid=0) are not counted.
    // Both counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bubbles_q <= 32'd0;
            stat_stalls_q  <= 32'd0;
        end else begin
            if (flush || (!stall && load_use)) begin
                stat_bubbles_q <= stat_bubbles_q + 32'd1;
            end
            if (stall) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_bubbles = stat_bubbles_q;
    assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for id_ex_stage. It runs in three parts:
//   - Directed forwarding vectors, taken from a table.
//   - Hand-written sequences for reset, load-use, flush and stall.
//   - Randomized cycles compared against a slot-level reference model.
//
// Inputs are driven on the falling edge.
// Outputs are sampled 1 ns after the falling edge.
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_ctrl;
    logic        id_src_a;
    logic        id_src_b;
    logic [4:0]  id_ctl;
    logic        stall;
    logic        flush;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        mem_we;
    logic        wb_we;
    logic [31:0] mem_fwd;
    logic [31:0] wb_fwd;
    logic        load_use;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_ctl;
    logic [31:0] ex_pc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] ex_store_data;
`ifdef ID_EX_STATS_EN
    logic [31:0] stat_bubbles;
    logic [31:0] stat_stalls;
`endif

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_ctl(id_ctl), .stall(stall), .flush(flush),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_we(mem_we), .wb_we(wb_we),
        .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .load_use(load_use),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_ctl(ex_ctl), .ex_pc(ex_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data)
`ifdef ID_EX_STATS_EN
        , .stat_bubbles(stat_bubbles), .stat_stalls(stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently sitting in EX.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        sa;
        logic        sb;
        logic [4:0]  ctl;
    } mslot_t;

    mslot_t model;

    // Directed forwarding vectors.
    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        sa;
        logic        sb;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mfwd;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wfwd;
        logic [31:0] expA;
        logic [31:0] expB;
        logic [31:0] expSt;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] imm,
                                 input logic [3:0] alu, input logic sa,
                                 input logic sb, input logic [4:0] ctl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_alu_ctrl = alu;
        id_src_a    = sa;
        id_src_b    = sb;
        id_ctl      = ctl;
    endtask

    task automatic setFwd(input logic mwe, input logic [4:0] mrd,
                          input logic [31:0] mf, input logic wwe,
                          input logic [4:0] wrd, input logic [31:0] wf);
        mem_we  = mwe;
        mem_rd  = mrd;
        mem_fwd = mf;
        wb_we   = wwe;
        wb_rd   = wrd;
        wb_fwd  = wf;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Picks the newest producer of a source register.
    // x0 always reads as the register value.
    function automatic logic [31:0] pickSrc(input logic [4:0] rs,
                                            input logic [31:0] regval);
        if (rs == 5'd0) return regval;
        if (mem_we && mem_rd == rs) return mem_fwd;
        if (wb_we && wb_rd == rs) return wb_fwd;
        return regval;
    endfunction

    function automatic logic modelLoadUse(input mslot_t s);
        return id_valid && s.valid && s.ctl[3] && s.rd != 5'd0 &&
               (s.rd == id_rs1 || s.rd == id_rs2);
    endfunction

    function automatic mslot_t modelNext(input mslot_t s);
        mslot_t n;
        if (flush) begin
            n = '0;
        end else if (stall) begin
            n = s;
        end else if (modelLoadUse(s) || !id_valid) begin
            n = '0;
        end else begin
            n = '{valid: 1'b1, pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                  d1: id_rs1_data, d2: id_rs2_data, imm: id_imm,
                  alu: id_alu_ctrl, sa: id_src_a, sb: id_src_b, ctl: id_ctl};
        end
        return n;
    endfunction

    task automatic checkAgainstModel();
        logic [31:0] f2;
        f2 = pickSrc(model.rs2, model.d2);
        checkOutput("rnd_load_use", {31'd0, load_use}, {31'd0, modelLoadUse(model)});
        checkOutput("rnd_ex_valid", {31'd0, ex_valid}, {31'd0, model.valid});
        checkOutput("rnd_ex_rd", {27'd0, ex_rd}, {27'd0, model.rd});
        checkOutput("rnd_ex_ctl", {27'd0, ex_ctl}, {27'd0, model.ctl});
        checkOutput("rnd_ex_pc", ex_pc, model.pc);
        checkOutput("rnd_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, model.alu});
        checkOutput("rnd_alu_a", alu_a, model.sa ? model.pc : pickSrc(model.rs1, model.d1));
        checkOutput("rnd_alu_b", alu_b, model.sb ? model.imm : f2);
        checkOutput("rnd_store", ex_store_data, f2);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h10, 32'h0, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 32'd7};
        vecs[1] = '{5'd4, 5'd9, 5'd8, 32'd1, 32'd2, 32'h14, 32'h0, 1'b0, 1'b0,
                    1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, 32'hAA, 32'd2, 32'd2};
        vecs[2] = '{5'd4, 5'd9, 5'd8, 32'd1, 32'd2, 32'h18, 32'h0, 1'b0, 1'b0,
                    1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, 32'hBB, 32'd2, 32'd2};
        vecs[3] = '{5'd0, 5'd9, 5'd8, 32'h11, 32'd2, 32'h1C, 32'h0, 1'b0, 1'b0,
                    1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'h11, 32'd2, 32'd2};
        vecs[4] = '{5'd1, 5'd6, 5'd2, 32'd9, 32'd3, 32'h100, 32'h44, 1'b1, 1'b1,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hCC, 32'h100, 32'h44, 32'hCC};
        vecs[5] = '{5'd1, 5'd7, 5'd2, 32'd9, 32'd3, 32'h104, 32'h0, 1'b0, 1'b0,
                    1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 32'h66, 32'd9, 32'h55, 32'h55};

        rst_n = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                      4'd0, 1'b0, 1'b0, 5'd0);
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        rst_n = 1'b1;

        // Directed forwarding table.
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                          vecs[i].d1, vecs[i].d2, vecs[i].imm, 4'd0,
                          vecs[i].sa, vecs[i].sb, 5'b10000);
            setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            tick();
            id_valid = 1'b0;
            setFwd(vecs[i].mwe, vecs[i].mrd, vecs[i].mfwd,
                   vecs[i].wwe, vecs[i].wrd, vecs[i].wfwd);
            #1;
            checkOutput($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].expA);
            checkOutput($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].expB);
            checkOutput($sformatf("vec%0d_store", i), ex_store_data, vecs[i].expSt);
            checkOutput($sformatf("vec%0d_ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
            checkOutput($sformatf("vec%0d_ex_valid", i), {31'd0, ex_valid}, 32'd1);
        end
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset asserted in the middle of a cycle.
        applyStimulus(1'b1, 32'h40, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0,
                      4'd5, 1'b0, 1'b0, 5'b11000);
        tick();
        #1;
        checkOutput("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("midreset_ctl", {27'd0, ex_ctl}, 32'd0);
        checkOutput("midreset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        tick();
        checkOutput("inreset_valid", {31'd0, ex_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("released_valid", {31'd0, ex_valid}, 32'd0);
        tick();
        checkOutput("after_release_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("after_release_alu", {28'd0, alu_ctrl}, 32'd5);

        // Load-use: LW x5, then ADD x6,x5,x1.
        applyStimulus(1'b1, 32'h80, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h8,
                      4'd0, 1'b0, 1'b1, 5'b11000);
        tick();
        applyStimulus(1'b1, 32'h84, 5'd5, 5'd1, 5'd6, 32'hDEAD, 32'd3, 32'h0,
                      4'd0, 1'b0, 1'b0, 5'b10000);
        #1;
        checkOutput("lu_detect", {31'd0, load_use}, 32'd1);
        tick();
        #1;
        checkOutput("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("lu_bubble_rd", {27'd0, ex_rd}, 32'd0);
        checkOutput("lu_dropped", {31'd0, load_use}, 32'd0);
        setFwd(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        tick();
        #1;
        checkOutput("lu_capture_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("lu_capture_rd", {27'd0, ex_rd}, 32'd6);
        checkOutput("lu_fwd_a", alu_a, 32'h1234);
        checkOutput("lu_b", alu_b, 32'd3);
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Flush together with stall writes a bubble.
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        #1;
        checkOutput("flush_stall_valid", {31'd0, ex_valid}, 32'd0);

        // Stall alone holds the slot for 3 cycles.
        applyStimulus(1'b1, 32'h200, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'h0,
                      4'd3, 1'b0, 1'b0, 5'b10000);
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h300 + k, 5'd3, 5'd4, 5'd10 + 5'(k), 32'd7,
                          32'd8, 32'h0, 4'd6, 1'b0, 1'b0, 5'b00001);
            tick();
            #1;
            checkOutput($sformatf("stall%0d_rd", k), {27'd0, ex_rd}, 32'd9);
            checkOutput($sformatf("stall%0d_pc", k), ex_pc, 32'h200);
            checkOutput($sformatf("stall%0d_alu", k), {28'd0, alu_ctrl}, 32'd3);
        end
        stall = 1'b0;

        // Randomized run against the reference model.
        doReset();
        model = '0;
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 5) != 0, $urandom, 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          $urandom, $urandom, $urandom, 4'($urandom),
                          1'($urandom), 1'($urandom), 5'($urandom));
            setFwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 5) == 0);
            #1;
            checkAgainstModel();
            model = modelNext(model);
            tick();
        end
        flush = 1'b0;
        stall = 1'b0;

`ifdef ID_EX_STATS_EN
        // Event counters: 2 flushes, 1 load-use and 3 stalls.
        doReset();
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                      4'd0, 1'b0, 1'b0, 5'd0);
        flush = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        applyStimulus(1'b1, 32'h0, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0,
                      4'd0, 1'b0, 1'b0, 5'b11000);
        tick();
        applyStimulus(1'b1, 32'h4, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0,
                      4'd0, 1'b0, 1'b0, 5'b10000);
        tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        #1;
        checkOutput("stat_bubbles", stat_bubbles, 32'd3);
        checkOutput("stat_stalls", stat_stalls, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
